// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter feeding a single-entry CDC send channel; CDC_ARB_STATS_EN adds per-requester grant counters.
// valid_src rises one cycle after acceptance; ready_src low in IDLE stalls req_ready, WAIT ends on a ready low->high or timeout.
module cdc_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk_src,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           data_src,
  output logic                        valid_src,
  input  logic                        ready_src,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  last_grant,
  output logic                        timeout_err
`ifdef CDC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t             state, state_nxt;
  logic               armed;
  logic [7:0]         wait_cnt;
  logic               seen_low;
  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               found;
  int                 rr_j;
  logic               accept;
  logic               done;

  // First set request at or after last_grant+1, wrapping modulo NUM_REQ.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    rr_j    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_j = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[rr_j]) begin
        found        = 1'b1;
        win_oh[rr_j] = 1'b1;
        win_idx      = IW'(rr_j);
      end
    end
  end

  // armed holds off acceptance until the first edge after reset release.
  assign req_ready   = (state == IDLE && armed && ready_src) ? win_oh : '0;
  assign accept      = |(req_valid & req_ready);
  assign done        = seen_low && ready_src;
  assign busy        = (state != IDLE);
  assign timeout_err = (state == WAIT) && !done && (wait_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (done || wait_cnt == TO_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      valid_src  <= 1'b0;
      data_src   <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      wait_cnt   <= '0;
      seen_low   <= 1'b0;
    end else begin
      state     <= state_nxt;
      armed     <= 1'b1;
      valid_src <= (state == SEND);
      if (accept) begin
        data_src   <= req_data[int'(win_idx)*DATA_W +: DATA_W];
        last_grant <= win_idx;
      end
      if (state == SEND) begin
        wait_cnt <= '0;
        seen_low <= 1'b0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (!ready_src) seen_low <= 1'b1;
      end
    end
  end

`ifdef CDC_ARB_STATS_EN
  // Counted at acceptance, so a send that later times out still counts.
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win_idx == IW'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed bench for cdc_tx_arbiter: cycle vector table plus round-robin, timeout, reset and stats sequences.
module tb_cdc_tx_arbiter;

  logic        clk_src = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  data_src;
  logic        valid_src;
  logic        ready_src;
  logic        busy;
  logic [1:0]  last_grant;
  logic        timeout_err;
`ifdef CDC_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int failures = 0;

  cdc_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(64)) dut (
    .clk_src     (clk_src),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .data_src    (data_src),
    .valid_src   (valid_src),
    .ready_src   (ready_src),
    .busy        (busy),
    .last_grant  (last_grant),
    .timeout_err (timeout_err)
`ifdef CDC_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk_src = ~clk_src;

  typedef struct {
    logic [3:0] rv;
    logic       rs;
    logic [3:0] rdy;
    logic       vld;
    logic [7:0] dat;
    logic       bsy;
    logic [1:0] lg;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  int exp_g[5] = '{0, 1, 2, 3, 0};
  int exp_d[5] = '{10, 20, 30, 40, 10};
  int got_g[5];
  int got_d[5];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, act, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk_src);
    #1;
  endtask

  task automatic do_reset(input int tag);
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    ready_src = 1'b1;
    #1;
    chk("rst_busy", tag, 64'(busy), 64'd0);
    chk("rst_valid", tag, 64'(valid_src), 64'd0);
    chk("rst_data", tag, 64'(data_src), 64'd0);
    chk("rst_lg", tag, 64'(last_grant), 64'd3);
    chk("rst_to", tag, 64'(timeout_err), 64'd0);
    chk("rst_rdy", tag, 64'(req_ready), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_one(input logic [3:0] rv, input int tag);
    req_valid = rv;
    ready_src = 1'b1;
    for (int c = 0; c < 10 && !busy; c++) tick();
    chk("send_accept", tag, 64'(busy), 64'd1);
    req_valid = 4'b0000;
    tick();
    ready_src = 1'b0;
    tick();
    ready_src = 1'b1;
    tick();
    chk("send_done", tag, 64'(busy), 64'd0);
  endtask

  int since;
  int ng;
  int npulse;
  int pulse_at;
  int to_rr;

  initial begin
    req_data = {8'd40, 8'd30, 8'd20, 8'd10};
    //          rv       rs    rdy      vld   dat     bsy   lg
    vt[0]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 8'd0,  1'b0, 2'd3};
    vt[1]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 8'd10, 1'b1, 2'd0};
    vt[2]  = '{4'b0001, 1'b1, 4'b0000, 1'b1, 8'd10, 1'b1, 2'd0};
    vt[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'd10, 1'b1, 2'd0};
    vt[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'd10, 1'b1, 2'd0};
    vt[5]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 8'd10, 1'b0, 2'd0};
    vt[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 8'd10, 1'b0, 2'd0};
    vt[7]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 8'd10, 1'b0, 2'd0};
    vt[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 8'd30, 1'b1, 2'd2};
    vt[9]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 8'd30, 1'b1, 2'd2};
    vt[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'd30, 1'b1, 2'd2};
    vt[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'd30, 1'b0, 2'd2};
    vt[12] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 8'd40, 1'b1, 2'd3};
    vt[13] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'd40, 1'b1, 2'd3};
    vt[14] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 8'd40, 1'b1, 2'd3};
    vt[15] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'd40, 1'b0, 2'd3};
    vt[16] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 8'd10, 1'b1, 2'd0};

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    ready_src = 1'b1;
    tick();
    do_reset(0);

    // Vector 0 is the cycle before the first post-reset edge: no accept yet.
    for (int i = 0; i < NV; i++) begin
      req_valid = vt[i].rv;
      ready_src = vt[i].rs;
      #1;
      chk("vec_rdy", i, 64'(req_ready), 64'(vt[i].rdy));
      tick();
      chk("vec_valid", i, 64'(valid_src), 64'(vt[i].vld));
      chk("vec_data", i, 64'(data_src), 64'(vt[i].dat));
      chk("vec_busy", i, 64'(busy), 64'(vt[i].bsy));
      chk("vec_lg", i, 64'(last_grant), 64'(vt[i].lg));
    end

    // Round robin with a CDC model: ready_src low for 3 cycles, 2 cycles after valid.
    do_reset(1);
    req_valid = 4'b1111;
    since = -1;
    ng = 0;
    to_rr = 0;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      ready_src = !(since >= 2 && since <= 4);
      tick();
      if (timeout_err) to_rr++;
      if (valid_src) begin
        got_g[ng] = int'(last_grant);
        got_d[ng] = int'(data_src);
        ng++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
    end
    chk("rr_count", 0, 64'(ng), 64'd5);
    chk("rr_timeout", 0, 64'(to_rr), 64'd0);
    for (int g = 0; g < ng; g++) begin
      chk("rr_grant", g, 64'(got_g[g]), 64'(exp_g[g]));
      chk("rr_data", g, 64'(got_d[g]), 64'(exp_d[g]));
    end

    // Timeout: ready_src never drops after the send.
    do_reset(2);
    req_valid = 4'b0001;
    ready_src = 1'b1;
    tick();
    tick();
    chk("to_accept", 0, 64'(busy), 64'd1);
    req_valid = 4'b0000;
    tick();
    npulse = 0;
    pulse_at = -1;
    for (int k = 0; k < 64; k++) begin
      if (timeout_err) begin
        npulse++;
        pulse_at = k;
      end
      tick();
    end
    chk("to_pulses", 0, 64'(npulse), 64'd1);
    chk("to_when", 0, 64'(pulse_at), 64'd63);
    chk("to_busy", 0, 64'(busy), 64'd0);
    chk("to_err_clr", 0, 64'(timeout_err), 64'd0);
    req_valid = 4'b0010;
    #1;
    chk("to_next_rdy", 0, 64'(req_ready), 64'b0010);
    tick();
    chk("to_next_lg", 0, 64'(last_grant), 64'd1);
    chk("to_next_data", 0, 64'(data_src), 64'd20);

    // Completion on the final WAIT cycle beats the timeout.
    req_valid = 4'b0000;
    tick();
    npulse = 0;
    for (int k = 0; k < 64; k++) begin
      ready_src = (k == 62) ? 1'b0 : 1'b1;
      #1;
      if (timeout_err) npulse++;
      if (k == 63) chk("prio_busy", 0, 64'(busy), 64'd1);
      tick();
    end
    chk("prio_pulses", 0, 64'(npulse), 64'd0);
    chk("prio_idle", 0, 64'(busy), 64'd0);

    // Reset in the middle of WAIT.
    req_valid = 4'b0100;
    tick();
    chk("mid_lg", 0, 64'(last_grant), 64'd2);
    req_valid = 4'b0000;
    repeat (10) tick();
    chk("mid_busy", 0, 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 0, 64'(busy), 64'd0);
    chk("mid_rst_valid", 0, 64'(valid_src), 64'd0);
    chk("mid_rst_lg", 0, 64'(last_grant), 64'd3);
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_first_rdy", 0, 64'(req_ready), 64'b0000);
    tick();
    chk("mid_arm_rdy", 0, 64'(req_ready), 64'b0001);
    tick();
    chk("mid_grant_lg", 0, 64'(last_grant), 64'd0);
    chk("mid_grant_data", 0, 64'(data_src), 64'd10);

`ifdef CDC_ARB_STATS_EN
    do_reset(3);
    chk("stats_rst", 0, grant_cnt, 64'd0);
    for (int n = 0; n < 5; n++) send_one(4'b0100, n);
    chk("stats_cnt", 0, grant_cnt, {16'd0, 16'd5, 16'd0, 16'd0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
